// File: rtl/acc_bank_if.sv
// rtl/acc_bank_if.sv - operand/update bus and registered status flags of the accumulator bank
interface acc_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                     en;
    logic [$clog2(DEPTH)-1:0] sel;
    logic [2:0]               op;
    logic [WIDTH-1:0]         in;
    logic [WIDTH-1:0]         out;
    logic                     z_out;
    logic                     c_out;
    logic                     n_out;
    logic                     v_out;

    modport master (
        output en, sel, op, in,
        input  out, z_out, c_out, n_out, v_out
    );

    modport slave (
        input  en, sel, op, in,
        output out, z_out, c_out, n_out, v_out
    );
endinterface

// File: rtl/acc_bank.sv
// rtl/acc_bank.sv - bank of DEPTH accumulators with one registered ALU update per cycle and Z/C/N/V flags
module acc_bank #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic        clk,
    input  logic        rst,
    acc_bank_if.slave   bus
);
    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    logic [WIDTH-1:0] acc [DEPTH];
    logic [WIDTH-1:0] a;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             c_nxt;
    logic             v_nxt;
    logic             z_q;
    logic             c_q;
    logic             n_q;
    logic             v_q;

    assign a    = acc[bus.sel];
    assign sum  = {1'b0, a} + {1'b0, bus.in};
    // The extra top bit of the widened difference is the unsigned borrow.
    assign diff = {1'b0, a} - {1'b0, bus.in};

    always_comb begin
        res   = '0;
        c_nxt = 1'b0;
        v_nxt = 1'b0;
        case (bus.op)
            OP_LOAD: res = bus.in;
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                c_nxt = sum[WIDTH];
                v_nxt = (a[WIDTH-1] == bus.in[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                if (SATURATE != 0 && sum[WIDTH]) res = '1;
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                c_nxt = diff[WIDTH];
                v_nxt = (a[WIDTH-1] != bus.in[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                if (SATURATE != 0 && diff[WIDTH]) res = '0;
            end
            OP_AND: res = a & bus.in;
            OP_OR:  res = a | bus.in;
            OP_XOR: res = a ^ bus.in;
            OP_SHL: begin
                res   = {a[WIDTH-2:0], 1'b0};
                c_nxt = a[WIDTH-1];
            end
            OP_SHR: begin
                res   = {1'b0, a[WIDTH-1:1]};
                c_nxt = a[0];
            end
            default: res = '0;
        endcase
    end

    // Flags track the last update only, independent of which index is currently read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
            z_q <= 1'b1;
            c_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (bus.en) begin
            acc[bus.sel] <= res;
            z_q <= (res == '0);
            c_q <= c_nxt;
            n_q <= res[WIDTH-1];
            v_q <= v_nxt;
        end
    end

    assign bus.out   = acc[bus.sel];
    assign bus.z_out = z_q;
    assign bus.c_out = c_q;
    assign bus.n_out = n_q;
    assign bus.v_out = v_q;
endmodule

// File: doc/acc_bank.md
Name: acc_bank

Overview:
- Parametrised successor to the single CPU accumulator.
- Holds DEPTH independent WIDTH-bit accumulators with a registered ALU-style update per cycle.
- Provides four registered status flags (Z, C, N, V) for the branch/condition logic of the one-cycle datapath.
- Sits between the operand mux and the condition unit. One accumulator is addressed per cycle for both read and update.

Parameters:
- WIDTH, 8, accumulator and operand width in bits; at least 2.
- DEPTH, 4, number of accumulators; a power of 2, at least 2.
- SATURATE, 0, 0 = ADD/SUB wrap modulo 2^WIDTH; 1 = unsigned saturation of ADD/SUB.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  update enable; when 0, all state holds.
- sel  input  $clog2(DEPTH)  accumulator index for read and update.
- op  input  3  operation code (see Behaviour).
- in  input  WIDTH  operand.
- out  output  WIDTH  contents of acc[sel] (combinational read of registered state).
- z_out  output  1  zero flag, registered.
- c_out  output  1  carry/borrow/shift-out flag, registered.
- n_out  output  1  negative flag (MSB of result), registered.
- v_out  output  1  signed overflow flag, registered.

Behaviour:
- Reset: on a rising clk edge with rst=1, all accumulators are cleared to 0, z_out=1, c_out=0, n_out=0, v_out=0. rst overrides en and op. Reset during any operation discards that operation. out reads 0 on the cycle after reset.
- Update: on a rising edge with rst=0 and en=1, acc[sel] is loaded with R and the flags are updated from R. Other accumulators are unchanged.
- Hold: with en=0, all accumulators and flags hold.
- Latency:
  - The written value is visible on out one cycle after the edge.
  - out follows sel combinationally in the same cycle.
  - Flags always describe the most recent update, regardless of the current sel.
- op encoding (A = acc[sel] before the edge):
  - 000 LOAD: R=in.
  - 001 ADD: R=A+in.
  - 010 SUB: R=A-in.
  - 011 AND: R=A&in.
  - 100 OR: R=A|in.
  - 101 XOR: R=A^in.
  - 110 SHL: R=A<<1, with 0 shifted into the LSB.
  - 111 SHR: logical R=A>>1, with 0 shifted into the MSB.
  - in is ignored for SHL and SHR.
- Carry (c_out):
  - ADD: carry out of bit WIDTH-1 of the raw sum.
  - SUB: borrow, i.e. 1 iff in > A unsigned.
  - SHL: old A[WIDTH-1].
  - SHR: old A[0].
  - LOAD and logic ops: 0.
- Overflow (v_out):
  - ADD: 1 iff A and in have equal MSBs and the raw-sum MSB differs.
  - SUB: 1 iff A and in have different MSBs and the raw-difference MSB differs from A's MSB.
  - All other ops: 0.
- Saturation (SATURATE=1):
  - ADD with carry clamps R to all ones.
  - SUB with borrow clamps R to 0.
  - c_out and v_out still come from the raw (unclamped) computation.
  - z_out and n_out come from the stored (clamped) R.
  - No clamping for other ops.
- Zero and negative flags: z_out = (R==0); n_out = R[WIDTH-1].
- Boundaries:
  - ADD of 0xFF+0x01 wraps to 0x00 (SATURATE=0).
  - SUB of 0x00-0x01 gives 0xFF with c_out=1.
  - Back-to-back updates of the same index chain correctly: each edge uses the previously stored value.
  - Alternating indices on consecutive edges do not interfere.
  - An en=0 cycle followed by en=1 resumes from the held value.
  - sel changing while en=0 only changes out.

Test Plan (WIDTH=8, DEPTH=4 unless stated):
- Reset then read: assert rst for 1 edge, sweep sel 0..3 -> out=0x00 for every sel; z=1, c=0, n=0, v=0.
- Load and hold per channel: LOAD 0x05 to sel=0, LOAD 0xA0 to sel=3, then en=0 for 3 cycles.
  - out reads 0x05 at sel=0, 0xA0 at sel=3, 0x00 at sel=1 and sel=2.
  - Flags after the last update: n=1, z=0.
- Arithmetic flags, SATURATE=0, on sel=1:
  - LOAD 0x7F, ADD 0x01 -> 0x80, v=1, n=1, c=0.
  - ADD 0x80 -> 0x00, c=1, z=1, v=1.
  - SUB 0x01 -> 0xFF, c=1, n=1, v=0.
- Saturation, SATURATE=1:
  - LOAD 0xF0, ADD 0x20 -> 0xFF, c=1.
  - LOAD 0x10, SUB 0x20 -> 0x00, c=1, z=1.
- Shifts and logic on sel=2:
  - LOAD 0x81, SHL -> 0x02, c=1.
  - SHR -> 0x01, c=0.
  - XOR 0x01 -> 0x00, z=1, c=0.
  - OR 0x0F -> 0x0F.
  - AND 0x3C -> 0x0C.
- Reset precedence: with en=1, op=ADD, in=0x05 and acc[0]=0x10, assert rst on that edge -> acc[0]=0x00 (not 0x15), z=1. The next edge with rst=0 and ADD 0x05 -> 0x05.
